// File: rtl/des_entry_pkg.sv
// des_entry_pkg: phase encodings, default sizes and illegal-state recovery target for des_entry_ctrl
package des_entry_pkg;
  localparam int NIBBLES_DEF = 16;
  localparam int W_DEF = 4 * NIBBLES_DEF;
  localparam int CNT_W_DEF = 4;
  typedef enum logic [2:0] {
    LOAD_KEY  = 3'd0,
    LOAD_DATA = 3'd1,
    RUN       = 3'd2,
    WAIT      = 3'd3,
    SHOW      = 3'd4
  } phase_e;
  localparam phase_e PHASE_RESET = LOAD_KEY;
  localparam phase_e PHASE_ILLEGAL_NEXT = LOAD_KEY;
endpackage

// File: rtl/nibble_shift_reg.sv
// nibble_shift_reg: word register that shifts nibble_in into the LSB on shift_en, cleared by rst/clr (clr wins over shift)
module nibble_shift_reg #(
  parameter int NIBBLES = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   clr,
  input  logic                   shift_en,
  input  logic [3:0]             nibble_in,
  output logic [4*NIBBLES-1:0]   word_out
);
  logic [4*NIBBLES-1:0] word_q, word_d;
  always_comb word_d = (rst || clr) ? '0 : shift_en ? {word_q[4*NIBBLES-5:0], nibble_in} : word_q;
  always_ff @(posedge clk) word_q <= word_d;
  assign word_out = word_q;
endmodule

// File: rtl/des_entry_ctrl.sv
// des_entry_ctrl: front-panel key/data nibble entry, DES core start strobe and result capture (clk, rst, enter/clr pulses, nibble_in, core_done/result -> key, data, core_start, result, result_valid, phase, nibble_cnt)
module des_entry_ctrl import des_entry_pkg::*; #(
  parameter  int NIBBLES = NIBBLES_DEF,
  parameter  int CNT_W   = CNT_W_DEF,
  localparam int W       = 4 * NIBBLES
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enter_pulse,
  input  logic             clr_pulse,
  input  logic [3:0]       nibble_in,
  input  logic             core_done,
  input  logic [W-1:0]     core_result,
  output logic [W-1:0]     key,
  output logic [W-1:0]     data,
  output logic             core_start,
  output logic [W-1:0]     result,
  output logic             result_valid,
  output logic [2:0]       phase,
  output logic [CNT_W-1:0] nibble_cnt
);
  phase_e state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0] result_q, result_d;
  logic last, loading, illegal, key_shift, data_shift, data_clr;
  assign last = cnt_q == CNT_W'(NIBBLES - 1);
  assign loading = state_q == LOAD_KEY || state_q == LOAD_DATA;
  assign illegal = state_q > SHOW;
  assign key_shift = !clr_pulse && enter_pulse && state_q == LOAD_KEY;
  assign data_shift = !clr_pulse && enter_pulse && state_q == LOAD_DATA;
  // data is emptied when a new block starts: key completion or leaving SHOW
  assign data_clr = clr_pulse || (key_shift && last) || (enter_pulse && state_q == SHOW);
  nibble_shift_reg #(.NIBBLES(NIBBLES)) u_key (
    .clk(clk), .rst(rst), .clr(clr_pulse), .shift_en(key_shift),
    .nibble_in(nibble_in), .word_out(key)
  );
  nibble_shift_reg #(.NIBBLES(NIBBLES)) u_data (
    .clk(clk), .rst(rst), .clr(data_clr), .shift_en(data_shift),
    .nibble_in(nibble_in), .word_out(data)
  );
  always_ff @(posedge clk) begin
    state_q <= state_d;
    cnt_q <= cnt_d;
    result_q <= result_d;
  end
  always_comb begin
    state_d = PHASE_ILLEGAL_NEXT;
    case (state_q)
      LOAD_KEY:  state_d = (enter_pulse && last) ? LOAD_DATA : LOAD_KEY;
      LOAD_DATA: state_d = (enter_pulse && last) ? RUN : LOAD_DATA;
      RUN:       state_d = WAIT;
      WAIT:      state_d = core_done ? SHOW : WAIT;
      SHOW:      state_d = enter_pulse ? LOAD_DATA : SHOW;
      default:   state_d = PHASE_ILLEGAL_NEXT;
    endcase
    if (rst || clr_pulse) state_d = PHASE_RESET;
    cnt_d = (rst || clr_pulse || illegal) ? '0 :
            (loading && enter_pulse) ? (last ? '0 : cnt_q + CNT_W'(1)) : cnt_q;
    // clr keeps the last result on display; only rst wipes it
    result_d = rst ? '0 : (state_q == WAIT && core_done && !clr_pulse) ? core_result : result_q;
  end
  always_comb begin
    core_start = state_q == RUN;
    result_valid = state_q == SHOW;
    phase = state_q;
    nibble_cnt = cnt_q;
    result = result_q;
  end
endmodule

// File: doc/des_entry_ctrl.md
Name: des_entry_ctrl

Overview:
- Consumes the one-cycle press pulses from the button rising-edge detector and assembles the 64-bit DES key and data block one hex nibble at a time from the switch bank.
- Issues a start pulse to the DES core and captures its result.
- Holds the result for display.
- Sits between the front-panel conditioning (debounce plus edge detect) and the DES core.

Parameters:
- NIBBLES, 16, number of 4-bit entries per word; word width W = 4*NIBBLES.
- CNT_W, 4, width of the nibble counter; must satisfy 2**CNT_W >= NIBBLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- enter_pulse  in  1  one-cycle pulse from the edge detector; accept the nibble.
- clr_pulse  in  1  one-cycle pulse; abandon all entry and restart at key entry.
- nibble_in  in  4  hex value from the switches, sampled only when enter_pulse=1.
- core_done  in  1  one-cycle pulse from the DES core; the result is valid.
- core_result  in  W  DES core output block.
- key  out  W  assembled key.
- data  out  W  assembled plaintext/ciphertext block.
- core_start  out  1  one-cycle start strobe to the DES core.
- result  out  W  captured core output.
- result_valid  out  1  high while in SHOW.
- phase  out  3  current state code, for LEDs.
- nibble_cnt  out  CNT_W  number of nibbles entered in the current word.

Behaviour:
- Reset (rst=1 at posedge clk):
  - State goes to LOAD_KEY.
  - key, data, result, nibble_cnt all go to 0.
  - core_start=0, result_valid=0.
- All outputs are registered or decoded directly from registered state. No combinational path from any input to any output.
- States: LOAD_KEY=0, LOAD_DATA=1, RUN=2, WAIT=3, SHOW=4. Codes 5-7 are illegal and recover to LOAD_KEY on the next clock.
- LOAD_KEY, on enter_pulse:
  - key <= {key[W-5:0], nibble_in}; the first nibble entered ends up most significant.
  - nibble_cnt increments.
  - If nibble_cnt == NIBBLES-1: nibble_cnt <= 0, data <= 0, next state is LOAD_DATA.
- LOAD_DATA: identical shifting into data. The final nibble moves the state to RUN.
- RUN: lasts exactly one cycle. core_start=1 only in this state. Next state is WAIT unconditionally.
- WAIT:
  - On core_done: result <= core_result, next state is SHOW.
  - enter_pulse is ignored.
  - No timeout.
- SHOW:
  - result_valid=1.
  - On enter_pulse: data <= 0, nibble_cnt <= 0, next state is LOAD_DATA. key is retained, so a new block can be entered under the same key. nibble_in is not shifted on this press.
- core_done outside WAIT is ignored; result is unchanged.
- clr_pulse, in any state:
  - Acts like reset, except result is retained and result_valid drops.
  - clr_pulse has priority over enter_pulse and core_done in the same cycle.
- core_done and enter_pulse together in WAIT: the done is captured and the enter is dropped.
- Latency:
  - Final data nibble press to core_start high: 1 cycle. The press is registered, the state becomes RUN, and the strobe appears in that cycle.
  - core_done to result_valid: 1 cycle.
- Back-to-back enter_pulse on consecutive cycles is legal; each pulse shifts one nibble.
- Synchronous reset asserted mid-entry or mid-WAIT discards everything. A late core_done is ignored.

Decomposition:
- Package des_entry_pkg holds:
  - the phase state encodings (LOAD_KEY..SHOW);
  - the default NIBBLES and W;
  - constants for the illegal-state default.
- Sub-module nibble_shift_reg (params NIBBLES):
  - ports clk, rst, clr, shift_en, nibble_in, word_out;
  - instantiated twice, for key and data.
- Counter and FSM stay in the top module.

Test Plan:
1. Reset, then 16 presses entering 1,3,3,4,5,7,7,9,9,B,B,C,D,F,F,1:
   - key=133457799BBCDFF1;
   - phase=1;
   - nibble_cnt=0.
2. Then 16 presses entering 0..F:
   - data=0123456789ABCDEF;
   - core_start high for exactly 1 cycle, 1 cycle after the last press;
   - phase=3.
3. In WAIT, drive core_done with core_result=85E813540F0AB405:
   - result=85E813540F0AB405;
   - result_valid=1 the next cycle;
   - enter_pulse asserted during WAIT does not change data.
4. In SHOW, press enter:
   - phase=1, data=0;
   - key unchanged (133457799BBCDFF1);
   - result_valid=0.
   - Entering a new 16-nibble block produces a second core_start.
5. After 7 key nibbles, assert clr_pulse and enter_pulse in the same cycle:
   - phase=0, key=0, nibble_cnt=0;
   - no shift occurs.
6. Pulse core_done while in LOAD_KEY:
   - result unchanged;
   - no state change.
   - Assert rst during WAIT, then send a late core_done: it is ignored, and all outputs match their reset values.
